// File: rtl/if_id_pipe.sv
// IF/ID pipeline boundary: multi-lane valid/ready stage with a one-entry skid
// buffer, decode stall hold, flush with NOP injection and a saturating stall counter.
module if_id_pipe #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       LANES     = 2,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES*DATA_W-1:0]   in_instr,
  input  logic [LANES*ADDR_W-1:0]   in_pc,
  output logic                      in_ready,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_valid,
  output logic [LANES*DATA_W-1:0]   out_instr,
  output logic [LANES*ADDR_W-1:0]   out_pc,
  output logic [CNT_W-1:0]          stall_cnt,
  input  logic                      clr_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e                    state_q, state_d;
  logic [LANES-1:0]          m_mask_q, m_mask_d, s_mask_q, s_mask_d;
  logic [LANES*DATA_W-1:0]   m_instr_q, m_instr_d, s_instr_q, s_instr_d;
  logic [LANES*ADDR_W-1:0]   m_pc_q, m_pc_d, s_pc_q, s_pc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      accept, take;

  // in_ready depends only on registered state, never on downstream inputs
  assign in_ready = (state_q != FULL);
  assign accept   = (|in_valid) & in_ready;
  assign take     = (|m_mask_q) & out_ready & ~stall;

  always_comb begin
    state_d   = state_q;
    m_mask_d  = m_mask_q;
    m_instr_d = m_instr_q;
    m_pc_d    = m_pc_q;
    s_mask_d  = s_mask_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;
    if (flush) begin
      // payload registers are kept so out_pc holds its last value
      state_d  = EMPTY;
      m_mask_d = '0;
      s_mask_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            m_mask_d  = in_valid;
            m_instr_d = in_instr;
            m_pc_d    = in_pc;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (take && accept) begin
            m_mask_d  = in_valid;
            m_instr_d = in_instr;
            m_pc_d    = in_pc;
          end else if (take) begin
            m_mask_d = '0;
            state_d  = EMPTY;
          end else if (accept) begin
            s_mask_d  = in_valid;
            s_instr_d = in_instr;
            s_pc_d    = in_pc;
            state_d   = FULL;
          end
        end
        FULL: begin
          if (take) begin
            m_mask_d  = s_mask_q;
            m_instr_d = s_instr_q;
            m_pc_d    = s_pc_q;
            s_mask_d  = '0;
            state_d   = ONE;
          end
        end
        default: begin
          state_d  = EMPTY;
          m_mask_d = '0;
          s_mask_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if ((|m_mask_q) && !take && !flush && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      m_mask_q  <= '0;
      s_mask_q  <= '0;
      m_instr_q <= {LANES{NOP_INSTR}};
      s_instr_q <= {LANES{NOP_INSTR}};
      m_pc_q    <= '0;
      s_pc_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      m_mask_q  <= m_mask_d;
      s_mask_q  <= s_mask_d;
      m_instr_q <= m_instr_d;
      s_instr_q <= s_instr_d;
      m_pc_q    <= m_pc_d;
      s_pc_q    <= s_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    out_instr = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      out_instr[i*DATA_W +: DATA_W] = m_mask_q[i] ? m_instr_q[i*DATA_W +: DATA_W] : NOP_INSTR;
    end
  end

  assign out_valid = m_mask_q;
  assign out_pc    = m_pc_q;
  assign stall_cnt = cnt_q;

endmodule
